// File: rtl/cpu_defs.sv
// Shared definitions for the 8-bit CPU control unit: state encodings,
// opcode values, bus-source codes and ALU operation codes.
package cpu_defs;

    // Control states. Any encoding not listed here is treated as illegal
    // and returns to F1.
    typedef enum logic [4:0] {
        F1   = 5'd0,
        F2   = 5'd1,
        F3   = 5'd2,
        DEC  = 5'd3,
        LD1  = 5'd4,
        LD2  = 5'd5,
        LD3  = 5'd6,
        LD4  = 5'd7,
        ST1  = 5'd8,
        ST2  = 5'd9,
        ST3  = 5'd10,
        ST4  = 5'd11,
        MV   = 5'd12,
        MR   = 5'd13,
        JP1  = 5'd14,
        JP2  = 5'd15,
        SKIP = 5'd16,
        ALU1 = 5'd17
    } state_t;

    // Opcodes live in ir[7:4]. Opcodes 8..15 are all single-state ALU ops.
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDAC = 4'd1;
    localparam logic [3:0] OP_STAC = 4'd2;
    localparam logic [3:0] OP_MVAC = 4'd3;
    localparam logic [3:0] OP_MOVR = 4'd4;
    localparam logic [3:0] OP_JUMP = 4'd5;
    localparam logic [3:0] OP_JMPZ = 4'd6;
    localparam logic [3:0] OP_JPNZ = 4'd7;

    // Bus source select codes.
    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_PC   = 3'd1;
    localparam logic [2:0] BUS_DR   = 3'd2;
    localparam logic [2:0] BUS_R    = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_MEM  = 3'd5;

    // ALU operation codes; they equal the low three opcode bits of 8..15.
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_NOT = 3'd5;
    localparam logic [2:0] ALU_INC = 3'd6;
    localparam logic [2:0] ALU_CLR = 3'd7;

    // Conditional-jump decision: JMPZ jumps on z=1, JPNZ jumps on z=0.
    function automatic logic jump_taken(input logic [3:0] op, input logic z);
        logic taken;
        if (op == OP_JMPZ) begin
            taken = z;
        end else begin
            taken = ~z;
        end
        return taken;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decoder: maps the current control state (plus the
// memory-ready handshake in wait states) onto the datapath strobes.
// When en is low every output is forced to zero.
module ctrl_decode
    import cpu_defs::*;
(
    input  state_t      state,
    input  logic [2:0]  alu_sel,
    input  logic        mem_rdy,
    input  logic        en,
    output logic        arload,
    output logic        arinc,
    output logic        pcload,
    output logic        pcinc,
    output logic        drload,
    output logic        irload,
    output logic        acload,
    output logic        rload,
    output logic        zload,
    output logic        ac_alu,
    output logic [2:0]  alu_op,
    output logic [2:0]  bus_src,
    output logic        read,
    output logic        write
);

    // Decode state into strobes; register loads in memory states wait for mem_rdy.
    always_comb begin
        arload  = 1'b0;
        arinc   = 1'b0;
        pcload  = 1'b0;
        pcinc   = 1'b0;
        drload  = 1'b0;
        irload  = 1'b0;
        acload  = 1'b0;
        rload   = 1'b0;
        zload   = 1'b0;
        ac_alu  = 1'b0;
        alu_op  = ALU_ADD;
        bus_src = BUS_NONE;
        read    = 1'b0;
        write   = 1'b0;
        if (en) begin
            case (state)
                F1, DEC: begin
                    bus_src = BUS_PC;
                    arload  = 1'b1;
                end
                F2, LD1, ST1: begin
                    // Instruction or operand-address fetch: PC advances with it.
                    read    = 1'b1;
                    bus_src = BUS_MEM;
                    drload  = mem_rdy;
                    pcinc   = mem_rdy;
                end
                F3: begin
                    bus_src = BUS_DR;
                    irload  = 1'b1;
                end
                LD2, ST2: begin
                    bus_src = BUS_DR;
                    arload  = 1'b1;
                end
                LD3, JP1: begin
                    read    = 1'b1;
                    bus_src = BUS_MEM;
                    drload  = mem_rdy;
                end
                LD4: begin
                    bus_src = BUS_DR;
                    acload  = 1'b1;
                end
                ST3: begin
                    bus_src = BUS_AC;
                    drload  = 1'b1;
                end
                ST4: begin
                    write   = 1'b1;
                    bus_src = BUS_DR;
                end
                MV: begin
                    bus_src = BUS_AC;
                    rload   = 1'b1;
                end
                MR: begin
                    bus_src = BUS_R;
                    acload  = 1'b1;
                end
                JP2: begin
                    bus_src = BUS_DR;
                    pcload  = 1'b1;
                end
                SKIP: begin
                    pcinc   = 1'b1;
                end
                ALU1: begin
                    bus_src = BUS_R;
                    acload  = 1'b1;
                    ac_alu  = 1'b1;
                    zload   = 1'b1;
                    alu_op  = alu_sel;
                end
                default: begin
                    bus_src = BUS_NONE;
                end
            endcase
        end else begin
            bus_src = BUS_NONE;
        end
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit for the 8-bit CPU: fetch / decode / execute
// sequencer. Holds the state register and next-state logic; strobes are a
// Moore decode of the state (gated by mem_rdy in wait states) done in
// ctrl_decode. Reset and run=0 force every strobe low immediately.
module cpu_ctrl_fsm
    import cpu_defs::*;
#(
    parameter int ST_W = 5,
    parameter int OP_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [7:0]      ir,
    input  logic            z,
    input  logic            mem_rdy,
    output logic            arload,
    output logic            arinc,
    output logic            pcload,
    output logic            pcinc,
    output logic            drload,
    output logic            irload,
    output logic            acload,
    output logic            rload,
    output logic            zload,
    output logic            ac_alu,
    output logic [2:0]      alu_op,
    output logic [2:0]      bus_src,
    output logic            read,
    output logic            write,
    output logic [ST_W-1:0] state_o
);

    state_t          state_r;
    logic [OP_W-1:0] opcode_s;
    logic            en_s;
    logic [3:0]      unused_ir_s;

    assign opcode_s    = ir[7 -: OP_W];
    assign unused_ir_s = ir[3:0];
    // rst is folded in combinationally so a pending write is dropped at once.
    assign en_s        = rst & run;
    assign state_o     = ST_W'(state_r);

    // State register and next-state logic; run=0 freezes the sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= F1;
        end else if (run) begin
            case (state_r)
                F1:  state_r <= F2;
                F2:  state_r <= mem_rdy ? F3 : F2;
                F3:  state_r <= DEC;
                DEC: begin
                    case (opcode_s)
                        OP_NOP:  state_r <= F1;
                        OP_LDAC: state_r <= LD1;
                        OP_STAC: state_r <= ST1;
                        OP_MVAC: state_r <= MV;
                        OP_MOVR: state_r <= MR;
                        OP_JUMP: state_r <= JP1;
                        OP_JMPZ, OP_JPNZ:
                            state_r <= jump_taken(opcode_s, z) ? JP1 : SKIP;
                        // Every remaining opcode (8..15) is a one-state ALU op.
                        default: state_r <= ALU1;
                    endcase
                end
                LD1:  state_r <= mem_rdy ? LD2 : LD1;
                LD2:  state_r <= LD3;
                LD3:  state_r <= mem_rdy ? LD4 : LD3;
                LD4:  state_r <= F1;
                ST1:  state_r <= mem_rdy ? ST2 : ST1;
                ST2:  state_r <= ST3;
                ST3:  state_r <= ST4;
                ST4:  state_r <= mem_rdy ? F1 : ST4;
                MV:   state_r <= F1;
                MR:   state_r <= F1;
                JP1:  state_r <= mem_rdy ? JP2 : JP1;
                JP2:  state_r <= F1;
                SKIP: state_r <= F1;
                ALU1: state_r <= F1;
                default: state_r <= F1;
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    ctrl_decode u_decode (
        .state   (state_r),
        .alu_sel (opcode_s[2:0]),
        .mem_rdy (mem_rdy),
        .en      (en_s),
        .arload  (arload),
        .arinc   (arinc),
        .pcload  (pcload),
        .pcinc   (pcinc),
        .drload  (drload),
        .irload  (irload),
        .acload  (acload),
        .rload   (rload),
        .zload   (zload),
        .ac_alu  (ac_alu),
        .alu_op  (alu_op),
        .bus_src (bus_src),
        .read    (read),
        .write   (write)
    );

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: directed scenarios followed by a
// randomized run checked against a micro-program reference model.
module tb_cpu_ctrl_fsm;
    import cpu_defs::*;

    logic       clk = 1'b0;
    logic       rst, run, z, mem_rdy;
    logic [7:0] ir;
    logic       arload, arinc, pcload, pcinc, drload, irload, acload, rload, zload;
    logic       ac_alu, read, write;
    logic [2:0] alu_op, bus_src;
    logic [4:0] state_o;
    logic [17:0] obs;

    int checks = 0;
    int errors = 0;

    // Load masks, ordered {arload, arinc, pcload, pcinc, drload, irload, acload, rload, zload}
    localparam logic [8:0] L_NONE = 9'b000000000;
    localparam logic [8:0] L_AR   = 9'b100000000;
    localparam logic [8:0] L_PCLD = 9'b001000000;
    localparam logic [8:0] L_PCI  = 9'b000100000;
    localparam logic [8:0] L_DR   = 9'b000010000;
    localparam logic [8:0] L_IR   = 9'b000001000;
    localparam logic [8:0] L_AC   = 9'b000000100;
    localparam logic [8:0] L_R    = 9'b000000010;
    localparam logic [8:0] L_Z    = 9'b000000001;

    typedef struct packed {
        logic [4:0] st;
        logic [2:0] bus;
        logic       rd;
        logic       wr;
        logic [8:0] ld;
        logic       acalu;
        logic [2:0] aop;
        logic       on_rdy;
    } step_t;

    step_t q[$];

    always #5 clk = ~clk;

    assign obs = {arload, arinc, pcload, pcinc, drload, irload, acload, rload, zload,
                  ac_alu, alu_op, bus_src, read, write};

    cpu_ctrl_fsm dut (
        .clk(clk), .rst(rst), .run(run), .ir(ir), .z(z), .mem_rdy(mem_rdy),
        .arload(arload), .arinc(arinc), .pcload(pcload), .pcinc(pcinc),
        .drload(drload), .irload(irload), .acload(acload), .rload(rload),
        .zload(zload), .ac_alu(ac_alu), .alu_op(alu_op), .bus_src(bus_src),
        .read(read), .write(write), .state_o(state_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    function automatic void push(input logic [4:0] st, input logic [2:0] bus, input logic rd,
                                 input logic wr, input logic [8:0] ld, input logic acalu,
                                 input logic [2:0] aop, input logic on_rdy);
        step_t s;
        s.st = st; s.bus = bus; s.rd = rd; s.wr = wr;
        s.ld = ld; s.acalu = acalu; s.aop = aop; s.on_rdy = on_rdy;
        q.push_back(s);
    endfunction

    // Micro-program of one whole instruction, written from the instruction semantics.
    function automatic void build(input logic [3:0] op, input logic zz);
        logic taken;
        q.delete();
        push(F1,  3'd1, 1'b0, 1'b0, L_AR,         1'b0, 3'd0, 1'b0);
        push(F2,  3'd5, 1'b1, 1'b0, L_DR | L_PCI, 1'b0, 3'd0, 1'b1);
        push(F3,  3'd2, 1'b0, 1'b0, L_IR,         1'b0, 3'd0, 1'b0);
        push(DEC, 3'd1, 1'b0, 1'b0, L_AR,         1'b0, 3'd0, 1'b0);
        taken = (op == 4'd5) || (op == 4'd6 && zz) || (op == 4'd7 && !zz);
        if (op >= 4'd8) begin
            push(ALU1, 3'd3, 1'b0, 1'b0, L_AC | L_Z, 1'b1, 3'(op - 4'd8), 1'b0);
        end else if (op == 4'd1) begin
            push(LD1, 3'd5, 1'b1, 1'b0, L_DR | L_PCI, 1'b0, 3'd0, 1'b1);
            push(LD2, 3'd2, 1'b0, 1'b0, L_AR,         1'b0, 3'd0, 1'b0);
            push(LD3, 3'd5, 1'b1, 1'b0, L_DR,         1'b0, 3'd0, 1'b1);
            push(LD4, 3'd2, 1'b0, 1'b0, L_AC,         1'b0, 3'd0, 1'b0);
        end else if (op == 4'd2) begin
            push(ST1, 3'd5, 1'b1, 1'b0, L_DR | L_PCI, 1'b0, 3'd0, 1'b1);
            push(ST2, 3'd2, 1'b0, 1'b0, L_AR,         1'b0, 3'd0, 1'b0);
            push(ST3, 3'd4, 1'b0, 1'b0, L_DR,         1'b0, 3'd0, 1'b0);
            push(ST4, 3'd2, 1'b0, 1'b1, L_NONE,       1'b0, 3'd0, 1'b1);
        end else if (op == 4'd3) begin
            push(MV, 3'd4, 1'b0, 1'b0, L_R, 1'b0, 3'd0, 1'b0);
        end else if (op == 4'd4) begin
            push(MR, 3'd3, 1'b0, 1'b0, L_AC, 1'b0, 3'd0, 1'b0);
        end else if (op >= 4'd5 && taken) begin
            push(JP1, 3'd5, 1'b1, 1'b0, L_DR,   1'b0, 3'd0, 1'b1);
            push(JP2, 3'd2, 1'b0, 1'b0, L_PCLD, 1'b0, 3'd0, 1'b0);
        end else if (op >= 4'd5) begin
            push(SKIP, 3'd0, 1'b0, 1'b0, L_PCI, 1'b0, 3'd0, 1'b0);
        end
    endfunction

    task automatic test_reset();
        rst = 1'b0; run = 1'b1; mem_rdy = 1'b1; ir = 8'h00; z = 1'b0;
        ticks(3);
        checks++;
        if (obs !== 18'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", obs);
        end
        checks++;
        if (state_o !== F1) begin
            errors++; $display("FAIL reset_state: got %0d want %0d", state_o, F1);
        end
    endtask

    task automatic test_nop_fetch();
        logic [4:0] exp_st [5];
        int pcinc_cnt;
        exp_st = '{F1, F2, F3, DEC, F1};
        pcinc_cnt = 0;
        rst = 1'b1; ir = 8'h00;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (state_o !== exp_st[i]) begin
                errors++; $display("FAIL nop_seq step %0d: got %0d want %0d", i, state_o, exp_st[i]);
            end
            if (pcinc) begin
                pcinc_cnt++;
                checks++;
                if (state_o !== F2) begin
                    errors++; $display("FAIL nop_pcinc_state: got %0d want %0d", state_o, F2);
                end
            end
            if (i < 4) tick();
        end
        checks++;
        if (pcinc_cnt != 1) begin
            errors++; $display("FAIL nop_pcinc_count: got %0d want 1", pcinc_cnt);
        end
    endtask

    task automatic test_alu_add();
        ir = 8'h80;
        ticks(4);
        checks++;
        if (state_o !== ALU1) begin
            errors++; $display("FAIL add_state: got %0d want %0d", state_o, ALU1);
        end
        checks++;
        if (obs !== {9'b000000101, 1'b1, 3'd0, 3'd3, 1'b0, 1'b0}) begin
            errors++; $display("FAIL add_outputs: got %h want %h", obs,
                               {9'b000000101, 1'b1, 3'd0, 3'd3, 1'b0, 1'b0});
        end
        tick();
        checks++;
        if (state_o !== F1) begin
            errors++; $display("FAIL add_return: got %0d want %0d", state_o, F1);
        end
    endtask

    task automatic test_ldac_wait();
        int rd_cnt;
        rd_cnt = 0;
        ir = 8'h10; mem_rdy = 1'b1;
        ticks(6);
        for (int k = 0; k < 4; k++) begin
            mem_rdy = (k == 3);
            #1;
            if (read) rd_cnt++;
            checks++;
            if (state_o !== LD3 || drload !== (k == 3)) begin
                errors++; $display("FAIL ld3_wait cyc %0d: state %0d drload %b want state %0d drload %b",
                                   k, state_o, drload, LD3, (k == 3));
            end
            tick();
        end
        mem_rdy = 1'b1;
        #1;
        checks++;
        if (rd_cnt != 4) begin
            errors++; $display("FAIL ld3_read_cycles: got %0d want 4", rd_cnt);
        end
        checks++;
        if (state_o !== LD4 || acload !== 1'b1 || ac_alu !== 1'b0) begin
            errors++; $display("FAIL ld4: state %0d acload %b ac_alu %b want %0d 1 0",
                               state_o, acload, ac_alu, LD4);
        end
        tick();
    endtask

    task automatic test_jmpz();
        ir = 8'h60; z = 1'b1; mem_rdy = 1'b1;
        ticks(4);
        checks++;
        if (state_o !== JP1) begin
            errors++; $display("FAIL jmpz_taken_jp1: got %0d want %0d", state_o, JP1);
        end
        tick();
        checks++;
        if (state_o !== JP2 || pcload !== 1'b1) begin
            errors++; $display("FAIL jmpz_jp2: state %0d pcload %b want %0d 1", state_o, pcload, JP2);
        end
        tick();
        z = 1'b0;
        ticks(4);
        checks++;
        if (state_o !== SKIP || pcinc !== 1'b1 || pcload !== 1'b0) begin
            errors++; $display("FAIL jmpz_skip: state %0d pcinc %b pcload %b want %0d 1 0",
                               state_o, pcinc, pcload, SKIP);
        end
        tick();
        checks++;
        if (state_o !== F1) begin
            errors++; $display("FAIL jmpz_return: got %0d want %0d", state_o, F1);
        end
    endtask

    task automatic test_stac_reset();
        ir = 8'h20; mem_rdy = 1'b1;
        ticks(7);
        mem_rdy = 1'b0;
        #1;
        checks++;
        if (state_o !== ST4 || write !== 1'b1) begin
            errors++; $display("FAIL st4_write: state %0d write %b want %0d 1", state_o, write, ST4);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (write !== 1'b0 || state_o !== F1 || obs !== 18'd0) begin
            errors++; $display("FAIL st4_async_reset: write %b state %0d outs %h want 0 %0d 0",
                               write, state_o, obs, F1);
        end
        tick();
        rst = 1'b1; ir = 8'h00;
        tick();
        checks++;
        if (state_o !== F2 || read !== 1'b1) begin
            errors++; $display("FAIL refetch: state %0d read %b want %0d 1", state_o, read, F2);
        end
        mem_rdy = 1'b1;
        ticks(3);
    endtask

    task automatic test_mvac_stall();
        ir = 8'h30;
        ticks(4);
        run = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (state_o !== MV || rload !== 1'b0) begin
                errors++; $display("FAIL mv_stall cyc %0d: state %0d rload %b want %0d 0",
                                   k, state_o, rload, MV);
            end
            tick();
        end
        run = 1'b1;
        #1;
        checks++;
        if (state_o !== MV || rload !== 1'b1) begin
            errors++; $display("FAIL mv_resume: state %0d rload %b want %0d 1", state_o, rload, MV);
        end
        tick();
        checks++;
        if (state_o !== F1 || rload !== 1'b0) begin
            errors++; $display("FAIL mv_done: state %0d rload %b want %0d 0", state_o, rload, F1);
        end
    endtask

    task automatic test_random(input int n_instr);
        logic [3:0]  op;
        logic [8:0]  ld_m;
        logic [17:0] exp_o;
        int          budget;
        for (int k = 0; k < n_instr; k++) begin
            op = 4'($urandom_range(0, 15));
            ir = {op, 4'($urandom)};
            z  = 1'($urandom);
            build(op, z);
            budget = 0;
            while (q.size() > 0 && budget < 100) begin
                run     = ($urandom_range(0, 99) < 85);
                mem_rdy = ($urandom_range(0, 99) < 55);
                #1;
                ld_m  = (q[0].on_rdy && !mem_rdy) ? L_NONE : q[0].ld;
                exp_o = run ? {ld_m, q[0].acalu, q[0].aop, q[0].bus, q[0].rd, q[0].wr} : 18'd0;
                checks++;
                if (state_o !== q[0].st) begin
                    errors++; $display("FAIL rnd_state instr %0d ir %h: got %0d want %0d",
                                       k, ir, state_o, q[0].st);
                end
                checks++;
                if (obs !== exp_o) begin
                    errors++; $display("FAIL rnd_outputs instr %0d ir %h state %0d run %b rdy %b: got %h want %h",
                                       k, ir, q[0].st, run, mem_rdy, obs, exp_o);
                end
                tick();
                if (run && (!q[0].on_rdy || mem_rdy)) void'(q.pop_front());
                budget++;
            end
            checks++;
            if (q.size() != 0) begin
                errors++; $display("FAIL rnd_timeout instr %0d: %0d steps left want 0", k, q.size());
                q.delete();
            end
        end
        run = 1'b1;
    endtask

    initial begin
        test_reset();
        test_nop_fetch();
        test_alu_add();
        test_ldac_wait();
        test_jmpz();
        test_stac_reset();
        test_mvac_stall();
        test_random(300);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Multi-cycle control unit for the 8-bit CPU datapath. Sequences fetch, decode and execute, and drives every register load/increment strobe. This includes the `rload` of the second-operand register R, plus the AR, PC, DR, IR, AC and Z loads, the bus-source select, the ALU op and the memory read/write strobes. The FSM is Moore: outputs decode from the current state only, except where gated by `mem_rdy`.

Parameters:
- ST_W, 5, state register width (exposed on `state_o`).
- OP_W, 4, opcode width; opcode = `ir[7:4]`.

Ports:
- clk  in  1  system clock (`clk_choose` from the clock-select block).
- rst  in  1  reset, asynchronous, active-low: 0 = reset, 1 = run.
- run  in  1  1 = advance; 0 = freeze the state and force all strobes to 0.
- ir  in  8  IR contents; only `ir[7:4]` is decoded.
- z  in  1  zero flag from the Z register.
- mem_rdy  in  1  memory completion for the current read/write.
- arload, arinc, pcload, pcinc, drload, irload, acload, rload, zload  out  1 each  register strobes.
- ac_alu  out  1  1 = AC loads the ALU result; 0 = AC loads the bus.
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 INC, 7 CLR.
- bus_src  out  3  0 none, 1 PC, 2 DR, 3 R, 4 AC, 5 MEM.
- read, write  out  1  memory strobes.
- state_o  out  ST_W  current state, for debug and the bench.

Behaviour:
- Reset and idle gating:
  - `rst`=0 asynchronously forces the state to F1.
  - While `rst`=0, every output except `state_o` is 0. This holds even mid-instruction: a partly executed instruction is abandoned and no write completes.
  - `run`=0 holds the state and forces all strobes to 0.
- Fetch and decode:
  - F1: AR<=PC (`bus_src`=1, `arload`).
  - F2: `read`=1, `bus_src`=5. Hold in F2 while `mem_rdy`=0. In the cycle `mem_rdy`=1, assert `drload` and `pcinc`, then go to F3.
  - F3: IR<=DR (`bus_src`=2, `irload`).
  - DEC: AR<=PC (`bus_src`=1, `arload`), then branch on `ir[7:4]`.
- Opcode 0 NOP: DEC -> F1.
- Opcode 1 LDAC, AC<=M[M[PC]]:
  - LD1: read operand. Wait for `mem_rdy`; `drload` and `pcinc` on the ready cycle.
  - LD2: AR<=DR.
  - LD3: read. Wait for `mem_rdy`; `drload` on the ready cycle.
  - LD4: AC<=DR (`bus_src`=2, `acload`, `ac_alu`=0). Then F1.
- Opcode 2 STAC, M[M[PC]]<=AC:
  - ST1 = LD1.
  - ST2: AR<=DR.
  - ST3: DR<=AC (`bus_src`=4, `drload`).
  - ST4: `write`=1, `bus_src`=2. Hold until `mem_rdy`. Then F1.
- Opcode 3 MVAC: one state, R<=AC (`bus_src`=4, `rload`).
- Opcode 4 MOVR: one state, AC<=R (`bus_src`=3, `acload`, `ac_alu`=0).
- Opcode 5 JUMP:
  - JP1: read; `drload` on `mem_rdy`.
  - JP2: PC<=DR (`bus_src`=2, `pcload`). Then F1.
- Opcodes 6 JMPZ / 7 JPNZ:
  - Condition taken (`z`=1 for JMPZ, `z`=0 for JPNZ): JP1 -> JP2.
  - Otherwise: SKIP state, one cycle of `pcinc`, then F1.
  - `z` is sampled in DEC.
- Opcodes 8–15 ALU (ADD, SUB, AND, OR, XOR, NOT, INAC, CLAC):
  - One state ALU1: `acload`, `ac_alu`=1, `zload`, `bus_src`=3.
  - `alu_op` = 0, 1, 2, 3, 4, 5, 6, 7 respectively.
- Invariants:
  - At most one of `read`/`write` is asserted.
  - Only one bus driver per cycle.
  - `pcinc` and `pcload` are never both asserted.
  - Unused state encodings go to F1.
- Memory wait: `mem_rdy` high in the first cycle of a memory state gives zero wait. Each low cycle adds exactly one cycle, with `read`/`write` held high.
- `run` falling in a wait state:
  - The strobe drops and the state is held.
  - On resume, the access restarts with the strobe high again.

Decomposition:
- Shared package `cpu_defs`:
  - state encodings F1, F2, F3, DEC, LD1..LD4, ST1..ST4, MV, MR, JP1, JP2, SKIP, ALU1;
  - opcode constants;
  - `bus_src` and `alu_op` codes.
- Optional sub-module `ctrl_decode`: combinational state -> strobe decoder. The state register and next-state logic stay in `cpu_ctrl_fsm`.

Test Plan:
- Release `rst` with `run`=1 and `mem_rdy`=1 tied high, `ir`=0x00 -> state sequence F1, F2, F3, DEC, F1. `pcinc` pulses once, in F2. All outputs are 0 while `rst`=0.
- `ir`=0x80 (ADD) -> in ALU1: `alu_op`=0, `ac_alu`=1, `acload`=1, `zload`=1, `bus_src`=3. Fetch to F1 takes 5 cycles total.
- `ir`=0x10 (LDAC), with `mem_rdy` low for 3 cycles in LD3:
  - `read` stays high 4 cycles;
  - `drload` asserts only on the 4th cycle;
  - LD4 then asserts `acload`.
- `ir`=0x60 (JMPZ): with `z`=1 -> JP1, JP2 with `pcload`. With `z`=0 -> SKIP with a single `pcinc`, no `pcload`.
- `ir`=0x20 (STAC): `rst` pulsed low during ST4 with `mem_rdy`=0 -> `write` drops immediately (asynchronously) and `state_o`=F1. After release, a fresh fetch begins.
- `ir`=0x30 (MVAC) then `run`=0 for 2 cycles in MV -> state held, `rload`=0 while stalled. `rload`=1 for exactly one cycle after `run` returns to 1.
